// File: rtl/power_sequencer_if.sv
// Board power-management signal bundle: control requests in, rail enables and status out.
`timescale 1ns/1ps
interface power_sequencer_if #(
   parameter int NUM_STAGES = 4
);
   logic                  enable;
   logic                  kill_sw;
   logic                  low_batt;
   logic                  heartbeat;
   logic                  clear_fault;
   logic                  shutdown_req;
   logic [NUM_STAGES-1:0] stage_en;
   logic [1:0]            fault_code;
   logic [2:0]            state;

   modport master (
      output enable, kill_sw, low_batt, heartbeat, clear_fault,
      input  shutdown_req, stage_en, fault_code, state
   );

   modport slave (
      input  enable, kill_sw, low_batt, heartbeat, clear_fault,
      output shutdown_req, stage_en, fault_code, state
   );
endinterface

// File: rtl/power_sequencer.sv
// Staged power-rail sequencer with debounced kill/low-battery inputs, CPU heartbeat
// watchdog and a latched first-fault code; shutdown_req gates every GPIO output low.
`timescale 1ns/1ps
module power_sequencer #(
   parameter int NUM_STAGES      = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int STAGE_DELAY     = 100000,
   parameter int WATCHDOG_CYCLES = 5000000
) (
   input logic              clk,
   input logic              reset,
   power_sequencer_if.slave bus
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int SD_W = $clog2(STAGE_DELAY) + 1;
   localparam int WD_W = $clog2(WATCHDOG_CYCLES) + 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [SD_W-1:0] SD_LAST = SD_W'(STAGE_DELAY - 1);
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WATCHDOG_CYCLES);

   typedef enum logic [2:0] {
      S_OFF      = 3'd0,
      S_POWER_UP = 3'd1,
      S_RUN      = 3'd2,
      S_SHUTDOWN = 3'd3,
      S_FAULT    = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [NUM_STAGES-1:0]   stage_q, stage_d, stage_cleared;
   logic                    sreq_q, sreq_d;
   logic [1:0]              fault_q, fault_d;
   logic                    step;

   logic [1:0]              raw, sync1, sync2, deb;
   logic [1:0][DB_W-1:0]    db_cnt;
   logic [WD_W-1:0]         wd_cnt;
   logic [SD_W-1:0]         stage_cnt;
   logic                    wd_cause, timer_done;
   logic [1:0]              cause_code;

   // Bit 0 is kill, bit 1 is low battery; debounced values start asserted so nothing powers up blind.
   assign raw = {bus.low_batt, bus.kill_sw};

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1  <= '0;
         sync2  <= '0;
         deb    <= '1;
         db_cnt <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               deb[i]    <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || bus.heartbeat || state_q != S_RUN) begin
         wd_cnt <= '0;
      end else if (wd_cnt != WD_MAX) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign wd_cause   = (state_q == S_RUN) && (wd_cnt == WD_MAX);
   assign timer_done = (stage_cnt == SD_LAST);
   assign stage_cleared = stage_q >> 1;

   always_comb begin
      cause_code = 2'd0;
      if (deb[0]) begin
         cause_code = 2'd1;
      end else if (deb[1]) begin
         cause_code = 2'd2;
      end else if (wd_cause) begin
         cause_code = 2'd3;
      end
   end

   // Stage timer restarts on every ramp step and on any state change.
   always_ff @(posedge clk) begin
      if (reset || step || state_d != state_q) begin
         stage_cnt <= '0;
      end else if (stage_cnt != SD_LAST) begin
         stage_cnt <= stage_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_OFF;
         stage_q <= '0;
         sreq_q  <= 1'b1;
         fault_q <= 2'd0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         sreq_q  <= sreq_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      sreq_d  = sreq_q;
      fault_d = fault_q;
      step    = 1'b0;
      case (state_q)
         S_OFF: begin
            stage_d = '0;
            sreq_d  = 1'b1;
            if (bus.enable && !deb[0] && !deb[1]) begin
               state_d = S_POWER_UP;
               stage_d = NUM_STAGES'(1);
            end
         end
         S_POWER_UP: begin
            sreq_d = 1'b1;
            if (cause_code != 2'd0) begin
               state_d = S_SHUTDOWN;
               fault_d = cause_code;
            end else if (!bus.enable) begin
               state_d = S_SHUTDOWN;
            end else if (timer_done) begin
               step = 1'b1;
               if (stage_q[NUM_STAGES-1]) begin
                  state_d = S_RUN;
                  sreq_d  = 1'b0;
               end else begin
                  stage_d = (stage_q << 1) | NUM_STAGES'(1);
               end
            end
         end
         S_RUN: begin
            if (cause_code != 2'd0) begin
               state_d = S_SHUTDOWN;
               sreq_d  = 1'b1;
               fault_d = cause_code;
            end else if (!bus.enable) begin
               state_d = S_SHUTDOWN;
               sreq_d  = 1'b1;
            end
         end
         S_SHUTDOWN: begin
            sreq_d = 1'b1;
            // First fault wins; later causes never overwrite a latched code.
            if (fault_q == 2'd0 && cause_code != 2'd0) begin
               fault_d = cause_code;
            end
            if (stage_q == '0) begin
               state_d = (fault_d != 2'd0) ? S_FAULT : S_OFF;
            end else if (timer_done) begin
               step    = 1'b1;
               stage_d = stage_cleared;
               if (stage_cleared == '0) begin
                  state_d = (fault_d != 2'd0) ? S_FAULT : S_OFF;
               end
            end
         end
         S_FAULT: begin
            stage_d = '0;
            sreq_d  = 1'b1;
            if (bus.clear_fault && cause_code == 2'd0) begin
               state_d = S_OFF;
               fault_d = 2'd0;
            end
         end
         default: begin
            state_d = S_OFF;
            stage_d = '0;
            sreq_d  = 1'b1;
            fault_d = 2'd0;
         end
      endcase
   end

   assign bus.shutdown_req = sreq_q;
   assign bus.stage_en     = stage_q;
   assign bus.fault_code   = fault_q;
   assign bus.state        = state_q;
endmodule

// File: tb/tb_power_sequencer.sv
// Scoreboard bench for power_sequencer: expectations are queued with the cycle they are due
// and compared against the DUT outputs on the falling edge of that cycle.
`timescale 1ns/1ps
module tb_power_sequencer;
   localparam int NS = 3;

   typedef struct {
      int    cyc;
      string tag;
      int    st;
      int    sr;
      int    se;
      int    fc;
   } exp_t;

   logic  clk;
   logic  reset;
   int    cycle      = 0;
   int    checks     = 0;
   int    passes     = 0;
   int    lastHbEdge = 0;
   int    hbCnt      = 0;
   bit    hbOn       = 1'b1;
   int    h;
   exp_t  sb[$];
   exp_t  cur;

   power_sequencer_if #(.NUM_STAGES(NS)) bus ();

   power_sequencer #(
      .NUM_STAGES(NS),
      .DEBOUNCE_CYCLES(4),
      .STAGE_DELAY(8),
      .WATCHDOG_CYCLES(32)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expected);
      checks++;
      if (obs !== expected) begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expected);
      end else begin
         passes++;
      end
   endtask

   task automatic expectAbs(input int cyc, input string tag, input int st, input int sr, input int se, input int fc);
      exp_t e;
      int   idx;
      e.cyc = cyc;
      e.tag = tag;
      e.st  = st;
      e.sr  = sr;
      e.se  = se;
      e.fc  = fc;
      idx = sb.size();
      while (idx > 0 && sb[idx-1].cyc > cyc) idx--;
      sb.insert(idx, e);
   endtask

   // Delta counts clock edges from now; 0 means the edge that just happened.
   task automatic expectAt(input int delta, input string tag, input int st, input int sr, input int se, input int fc);
      expectAbs(cycle + delta, tag, st, sr, se, fc);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic en, input logic kill, input logic lb);
      bus.enable   = en;
      bus.kill_sw  = kill;
      bus.low_batt = lb;
   endtask

   task automatic pulseClear();
      bus.clear_fault = 1'b1;
      step(1);
      bus.clear_fault = 1'b0;
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cycle) begin
         cur = sb.pop_front();
         checkOutput({cur.tag, ".state"}, 32'(bus.state), cur.st);
         checkOutput({cur.tag, ".shutdown_req"}, 32'(bus.shutdown_req), cur.sr);
         checkOutput({cur.tag, ".stage_en"}, 32'(bus.stage_en), cur.se);
         checkOutput({cur.tag, ".fault_code"}, 32'(bus.fault_code), cur.fc);
      end
   end

   // CPU heartbeat every 10 cycles while enabled; remembers the edge that sampled the last one.
   initial begin
      bus.heartbeat = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (hbOn && hbCnt >= 9) begin
            bus.heartbeat = 1'b1;
            hbCnt         = 0;
            lastHbEdge    = cycle + 1;
         end else begin
            bus.heartbeat = 1'b0;
            if (hbOn) hbCnt++;
         end
      end
   end

   initial begin
      reset = 1'b1;
      bus.clear_fault = 1'b0;
      applyStimulus(0, 0, 0);
      step(3);
      expectAt(0, "reset", 0, 1, 0, 0);
      reset = 1'b0;
      expectAt(2, "offIdle", 0, 1, 0, 0);
      step(12);

      $display("[TB] power-up");
      applyStimulus(1, 0, 0);
      expectAt(1, "pu1", 1, 1, 1, 0);
      expectAt(8, "pu1Hold", 1, 1, 1, 0);
      expectAt(9, "pu2", 1, 1, 3, 0);
      expectAt(16, "pu2Hold", 1, 1, 3, 0);
      expectAt(17, "pu3", 1, 1, 7, 0);
      expectAt(24, "pu3Hold", 1, 1, 7, 0);
      expectAt(25, "runEntry", 2, 0, 7, 0);
      step(30);
      pulseClear();
      expectAt(1, "clearInRun", 2, 0, 7, 0);
      step(4);

      $display("[TB] orderly off");
      applyStimulus(0, 0, 0);
      expectAt(1, "offReq", 3, 1, 7, 0);
      expectAt(8, "sd111", 3, 1, 7, 0);
      expectAt(9, "sd011", 3, 1, 3, 0);
      expectAt(17, "sd001", 3, 1, 1, 0);
      expectAt(24, "sd001Hold", 3, 1, 1, 0);
      expectAt(25, "offDone", 0, 1, 0, 0);
      step(30);

      $display("[TB] kill");
      applyStimulus(1, 0, 0);
      expectAt(25, "run2", 2, 0, 7, 0);
      step(30);
      applyStimulus(1, 1, 0);
      step(3);
      applyStimulus(1, 0, 0);
      expectAt(10, "killGlitch", 2, 0, 7, 0);
      step(12);
      applyStimulus(1, 1, 0);
      expectAt(6, "killPending", 2, 0, 7, 0);
      expectAt(7, "killShut", 3, 1, 7, 1);
      expectAt(15, "kill011", 3, 1, 3, 1);
      expectAt(30, "kill001", 3, 1, 1, 1);
      expectAt(31, "killFault", 4, 1, 0, 1);
      step(33);
      applyStimulus(0, 1, 0);
      pulseClear();
      expectAt(1, "clearIgnored", 4, 1, 0, 1);
      step(2);
      applyStimulus(0, 0, 0);
      step(10);
      pulseClear();
      expectAt(0, "killCleared", 0, 1, 0, 0);
      step(3);

      $display("[TB] watchdog");
      applyStimulus(1, 0, 0);
      expectAt(25, "run3", 2, 0, 7, 0);
      step(38);
      hbOn = 1'b0;
      step(1);
      h = lastHbEdge;
      expectAbs(h + 32, "wdPending", 2, 0, 7, 0);
      expectAbs(h + 33, "wdShut", 3, 1, 7, 3);
      expectAbs(h + 57, "wdFault", 4, 1, 0, 3);
      step(h + 60 - cycle);
      applyStimulus(0, 0, 0);
      pulseClear();
      expectAt(0, "wdCleared", 0, 1, 0, 0);
      hbOn = 1'b1;
      step(3);

      $display("[TB] priority and abort");
      applyStimulus(1, 0, 0);
      step(5);
      applyStimulus(1, 1, 1);
      expectAt(4, "abort011", 1, 1, 3, 0);
      expectAt(6, "abortPending", 1, 1, 3, 0);
      expectAt(7, "abortShut", 3, 1, 3, 1);
      expectAt(14, "abortHold", 3, 1, 3, 1);
      expectAt(15, "abort001", 3, 1, 1, 1);
      expectAt(23, "abortFault", 4, 1, 0, 1);
      step(25);
      applyStimulus(0, 0, 0);
      step(10);
      pulseClear();
      expectAt(0, "abortCleared", 0, 1, 0, 0);
      step(3);

      $display("[TB] reset mid-ramp");
      applyStimulus(1, 0, 0);
      expectAt(25, "run4", 2, 0, 7, 0);
      step(30);
      applyStimulus(1, 0, 1);
      expectAt(7, "lbShut", 3, 1, 7, 2);
      expectAt(15, "lb011", 3, 1, 3, 2);
      step(17);
      reset = 1'b1;
      step(1);
      expectAt(0, "resetMid", 0, 1, 0, 0);
      reset = 1'b0;
      applyStimulus(0, 0, 0);
      expectAt(2, "postReset", 0, 1, 0, 0);
      step(4);

      for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      checkOutput("drain", 32'(sb.size()), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/power_sequencer.md
# power_sequencer

Power-management controller for the top-level board I/O. It sequences the staged power-rail enables on power-up and power-down. It debounces the kill switch and low-battery indication and watchdogs the CPU heartbeat. It drives the `shutdown_req` line that feeds the GPIO global-disable gate, so every GPIO output is forced low whenever the system is not in normal run.

## Interface
- `NUM_STAGES`, 4: number of sequenced rail enables.
- `DEBOUNCE_CYCLES`, 50000: cycles an input must stay stable before its debounced value changes.
- `STAGE_DELAY`, 100000: cycles between successive stage enable and disable steps.
- `WATCHDOG_CYCLES`, 5000000: maximum cycles between heartbeats while in RUN.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  level; request to power up (1) or orderly power down (0).
- `kill_sw`  in  1  raw, asynchronous kill switch; 1 = killed.
- `low_batt`  in  1  raw, asynchronous low-battery comparator; 1 = low.
- `heartbeat`  in  1  single-cycle pulse from the CPU.
- `clear_fault`  in  1  single-cycle pulse; acknowledges a latched fault.
- `shutdown_req`  out  1  to the global-disable `shutdown` input; 1 = GPIO forced low.
- `stage_en`  out  NUM_STAGES  rail enables; bit 0 powers first.
- `fault_code`  out  2  0 none, 1 kill, 2 low battery, 3 watchdog.
- `state`  out  3  current FSM state, for debug: OFF=0, POWER_UP=1, RUN=2, SHUTDOWN=3, FAULT=4.

## Operation
- **Input conditioning.** `kill_sw` and `low_batt` each pass through a 2-flop synchronizer, then a debouncer. The debounced value changes only after the synchronized value has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. A glitch restarts the count. Debounced values reset to 1 (fail-safe).
- **Watchdog.** The counter clears on `heartbeat` and in every state except RUN. In RUN, if the counter reaches `WATCHDOG_CYCLES` with no heartbeat, the watchdog cause asserts.
- **Cause and priority.** The active cause is the highest-priority condition present: kill, then low battery, then watchdog.
- **Stage timer.** Counts `STAGE_DELAY` cycles per step and restarts on every step and on every state change.

FSM:
- **OFF.** `stage_en`=0 and `shutdown_req`=1. Moves to POWER_UP when `enable`=1 and neither debounced kill nor debounced low battery is active.
- **POWER_UP.** `stage_en[0]` sets on the entry cycle. Each further `STAGE_DELAY` sets the next bit. `STAGE_DELAY` after the last bit, the FSM moves to RUN. A cause or `enable`=0 moves it to SHUTDOWN immediately, without finishing the ramp.
- **RUN.** All stages are on and `shutdown_req`=0.
  - A cause latches `fault_code` and moves to SHUTDOWN.
  - `enable`=0 moves to SHUTDOWN with `fault_code` left at 0.
- **SHUTDOWN.** `shutdown_req`=1 on the entry cycle. Each `STAGE_DELAY`, the highest set `stage_en` bit clears; the first clear happens `STAGE_DELAY` after entry. Once all bits are clear, the FSM goes to FAULT if `fault_code`≠0, otherwise to OFF.
  - A cause that appears during a non-fault shutdown latches `fault_code`.
  - A cause seen while `fault_code` is already nonzero is ignored, so the first fault wins.
- **FAULT.** Outputs are the same as OFF; `fault_code` holds. Moves to OFF on a `clear_fault` pulse if no cause is active, clearing `fault_code`. Otherwise `clear_fault` is ignored.
- **Simultaneous events.** A cause and `enable`=0 in the same cycle: the cause wins and `fault_code` latches. `clear_fault` outside FAULT has no effect.

## Timing
- All outputs are registered. Reset values: `shutdown_req`=1, `stage_en`=0, `fault_code`=0, `state`=OFF. Debouncers reset to 1, and the synchronizer, watchdog and stage counters reset to 0.
- Reset asserted mid-sequence drops all stages in the next cycle, with no ordered ramp-down.
- Cause-to-`shutdown_req` latency: 1 cycle after the debounced or watchdog cause is registered.
- Raw kill edge to `shutdown_req`: at most 2 (sync) + `DEBOUNCE_CYCLES` + 2 cycles.
- `state`, `shutdown_req` and `stage_en` all update on the same clock edge as the transition.
- Full power-up from leaving OFF to RUN takes `NUM_STAGES`×`STAGE_DELAY` cycles. Full power-down from entering SHUTDOWN to the exit state takes `NUM_STAGES`×`STAGE_DELAY` cycles.
- Counter widths are `$clog2` of the respective parameter plus 1. Counters saturate and never wrap.

## Test plan
Bench parameters: `NUM_STAGES`=3, `DEBOUNCE_CYCLES`=4, `STAGE_DELAY`=8, `WATCHDOG_CYCLES`=32.

1. **Power-up.** Release reset with kill=0 and low_batt=0, wait for the debouncers to settle, then raise `enable`. Required: `stage_en` steps 001→011→111 at 8-cycle spacing, RUN is reached 24 cycles after leaving OFF, and `shutdown_req` falls on RUN entry.
2. **Orderly off.** In RUN with heartbeats every 10 cycles, drop `enable`. Required: `shutdown_req`=1 next cycle, `stage_en` steps 111→011→001→000 at 8-cycle spacing, FSM ends in OFF with `fault_code`=0.
3. **Kill.** In RUN, apply a 3-cycle kill pulse. Required: no effect. Then hold kill high. Required: `shutdown_req` rises within 8 cycles, ramp-down completes, FSM ends in FAULT with `fault_code`=1. `clear_fault` while kill is still high is ignored. After kill is released and debounced, `clear_fault` moves the FSM to OFF with `fault_code`=0.
4. **Watchdog.** In RUN, stop heartbeats. Required: the cause fires 32 cycles after the last heartbeat and the FSM ends in FAULT with `fault_code`=3.
5. **Priority and abort.** During POWER_UP at `stage_en`=011, assert low_batt and kill together. Required: SHUTDOWN is entered from 011, `fault_code`=1, and the first stage clears 8 cycles later.
6. **Reset mid-ramp.** Assert `reset` during SHUTDOWN. Required: next cycle `stage_en`=0, `shutdown_req`=1, `state`=OFF, `fault_code`=0.
